// File: rtl/dds_pkg.sv
// ============================================================================
//  Module      : dds_pkg
//  Description : Shared types for the decode/dispatch queue: op and unit
//                encodings, RV32I opcode classes and the dispatch record.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package dds_pkg;

   typedef enum logic [5:0] {
      OP_ADD   = 6'd0,
      OP_SUB   = 6'd1,
      OP_SLL   = 6'd2,
      OP_SLT   = 6'd3,
      OP_SLTU  = 6'd4,
      OP_XOR   = 6'd5,
      OP_SRL   = 6'd6,
      OP_SRA   = 6'd7,
      OP_OR    = 6'd8,
      OP_AND   = 6'd9,
      OP_LB    = 6'd10,
      OP_LH    = 6'd11,
      OP_LW    = 6'd12,
      OP_LBU   = 6'd13,
      OP_LHU   = 6'd14,
      OP_SB    = 6'd15,
      OP_SH    = 6'd16,
      OP_SW    = 6'd17,
      OP_BEQ   = 6'd18,
      OP_BNE   = 6'd19,
      OP_BLT   = 6'd20,
      OP_BGE   = 6'd21,
      OP_BLTU  = 6'd22,
      OP_BGEU  = 6'd23,
      OP_LUI   = 6'd24,
      OP_AUIPC = 6'd25,
      OP_JAL   = 6'd26,
      OP_JALR  = 6'd27
   } op_e;

   typedef enum logic [1:0] {
      UNIT_ALU    = 2'd0,
      UNIT_BRANCH = 2'd1,
      UNIT_LSU    = 2'd2
   } unit_e;

   localparam logic [6:0] c_opc_op     = 7'b0110011;
   localparam logic [6:0] c_opc_op_imm = 7'b0010011;
   localparam logic [6:0] c_opc_load   = 7'b0000011;
   localparam logic [6:0] c_opc_store  = 7'b0100011;
   localparam logic [6:0] c_opc_branch = 7'b1100011;
   localparam logic [6:0] c_opc_lui    = 7'b0110111;
   localparam logic [6:0] c_opc_auipc  = 7'b0010111;
   localparam logic [6:0] c_opc_jal    = 7'b1101111;
   localparam logic [6:0] c_opc_jalr   = 7'b1100111;

   localparam logic [31:0] c_nop = 32'h0000_0013;

   // Width-independent part of the record; imm and pc travel beside it.
   typedef struct packed {
      unit_e      unit;
      op_e        op;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } disp_rec_t;

endpackage

`default_nettype wire

// File: rtl/inst_decode_comb.sv
// ============================================================================
//  Module      : inst_decode_comb
//  Description : Combinational RV32I decode of one {inst, pc} pair into a
//                dispatch record, immediate, JAL target and class flags.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module inst_decode_comb
   import dds_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic [31:0]           inst,
   input  logic [ADDR_WIDTH-1:0] pc,
   output disp_rec_t             rec,
   output logic [DATA_WIDTH-1:0] imm,
   output logic [ADDR_WIDTH-1:0] jal_target,
   output logic                  is_nop,
   output logic                  is_illegal,
   output logic                  is_jal
);

   logic [6:0]  w_opc;
   logic [2:0]  w_f3;
   logic [6:0]  w_f7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_u;
   logic [31:0] w_imm_j;
   logic [31:0] w_imm32;
   logic        w_illegal;

   assign w_opc   = inst[6:0];
   assign w_f3    = inst[14:12];
   assign w_f7    = inst[31:25];
   assign w_imm_i = {{20{inst[31]}}, inst[31:20]};
   assign w_imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign w_imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign w_imm_u = {inst[31:12], 12'd0};
   assign w_imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   always_comb begin
      rec.unit  = UNIT_ALU;
      rec.op    = OP_ADD;
      rec.rd    = inst[11:7];
      rec.rs1   = inst[19:15];
      rec.rs2   = 5'd0;
      w_imm32   = 32'd0;
      w_illegal = 1'b0;
      case (w_opc)
         c_opc_op: begin
            rec.rs2 = inst[24:20];
            case (w_f3)
               3'd0:    rec.op = (w_f7 == 7'h20) ? OP_SUB : OP_ADD;
               3'd1:    rec.op = OP_SLL;
               3'd2:    rec.op = OP_SLT;
               3'd3:    rec.op = OP_SLTU;
               3'd4:    rec.op = OP_XOR;
               3'd5:    rec.op = (w_f7 == 7'h20) ? OP_SRA : OP_SRL;
               3'd6:    rec.op = OP_OR;
               default: rec.op = OP_AND;
            endcase
            if (!(w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5))))
               w_illegal = 1'b1;
         end
         c_opc_op_imm: begin
            w_imm32 = w_imm_i;
            case (w_f3)
               3'd0:    rec.op = OP_ADD;
               3'd1:    rec.op = OP_SLL;
               3'd2:    rec.op = OP_SLT;
               3'd3:    rec.op = OP_SLTU;
               3'd4:    rec.op = OP_XOR;
               3'd5:    rec.op = (w_f7 == 7'h20) ? OP_SRA : OP_SRL;
               3'd6:    rec.op = OP_OR;
               default: rec.op = OP_AND;
            endcase
            // Shift immediates carry only the shift amount.
            if (w_f3 == 3'd1 || w_f3 == 3'd5) begin
               w_imm32 = {27'd0, inst[24:20]};
               if (!(w_f7 == 7'h00 || (w_f3 == 3'd5 && w_f7 == 7'h20)))
                  w_illegal = 1'b1;
            end
         end
         c_opc_load: begin
            rec.unit = UNIT_LSU;
            w_imm32  = w_imm_i;
            case (w_f3)
               3'd0:    rec.op = OP_LB;
               3'd1:    rec.op = OP_LH;
               3'd2:    rec.op = OP_LW;
               3'd4:    rec.op = OP_LBU;
               3'd5:    rec.op = OP_LHU;
               default: w_illegal = 1'b1;
            endcase
         end
         c_opc_store: begin
            rec.unit = UNIT_LSU;
            rec.rd   = 5'd0;
            rec.rs2  = inst[24:20];
            w_imm32  = w_imm_s;
            case (w_f3)
               3'd0:    rec.op = OP_SB;
               3'd1:    rec.op = OP_SH;
               3'd2:    rec.op = OP_SW;
               default: w_illegal = 1'b1;
            endcase
         end
         c_opc_branch: begin
            rec.unit = UNIT_BRANCH;
            rec.rd   = 5'd0;
            rec.rs2  = inst[24:20];
            w_imm32  = w_imm_b;
            case (w_f3)
               3'd0:    rec.op = OP_BEQ;
               3'd1:    rec.op = OP_BNE;
               3'd4:    rec.op = OP_BLT;
               3'd5:    rec.op = OP_BGE;
               3'd6:    rec.op = OP_BLTU;
               3'd7:    rec.op = OP_BGEU;
               default: w_illegal = 1'b1;
            endcase
         end
         c_opc_lui: begin
            rec.op  = OP_LUI;
            rec.rs1 = 5'd0;
            w_imm32 = w_imm_u;
         end
         c_opc_auipc: begin
            rec.op  = OP_AUIPC;
            rec.rs1 = 5'd0;
            w_imm32 = w_imm_u;
         end
         c_opc_jal: begin
            rec.op  = OP_JAL;
            rec.rs1 = 5'd0;
            w_imm32 = w_imm_j;
         end
         c_opc_jalr: begin
            rec.unit = UNIT_BRANCH;
            rec.op   = OP_JALR;
            w_imm32  = w_imm_i;
            if (w_f3 != 3'd0)
               w_illegal = 1'b1;
         end
         default: w_illegal = 1'b1;
      endcase
   end

   assign imm        = DATA_WIDTH'($signed(w_imm32));
   assign jal_target = pc + ADDR_WIDTH'($signed(w_imm_j));
   assign is_nop     = (inst == c_nop);
   assign is_illegal = w_illegal;
   assign is_jal     = (w_opc == c_opc_jal);

endmodule

`default_nettype wire

// File: rtl/decode_dispatch_queue.sv
// ============================================================================
//  Module      : decode_dispatch_queue
//  Description : Circular fetch queue feeding a registered dispatch record,
//                with local JAL redirect and a stall behind branches/JALR.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module decode_dispatch_queue
   import dds_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  if_valid,
   input  logic [31:0]           if_inst,
   input  logic [ADDR_WIDTH-1:0] if_pc,
   output logic                  if_ready,
   input  logic                  flush,
   input  logic                  br_resolve,
   output logic                  disp_valid,
   input  logic                  disp_ready,
   output logic [1:0]            disp_unit,
   output logic [5:0]            disp_op,
   output logic [4:0]            disp_rd,
   output logic [4:0]            disp_rs1,
   output logic [4:0]            disp_rs2,
   output logic [DATA_WIDTH-1:0] disp_imm,
   output logic [ADDR_WIDTH-1:0] disp_pc,
   output logic                  pc_redirect_valid,
   output logic [ADDR_WIDTH-1:0] pc_redirect_target,
   output logic                  illegal_inst,
   output logic [CNT_WIDTH-1:0]  queue_count,
   output logic                  waiting_branch
);

   localparam int PTR_W = $clog2(DEPTH);

   localparam logic [0:0] S_RUN     = 1'b0;
   localparam logic [0:0] S_WAIT_BR = 1'b1;

   logic [31:0]           r_q_inst [DEPTH];
   logic [ADDR_WIDTH-1:0] r_q_pc   [DEPTH];
   logic [PTR_W-1:0]      r_head;
   logic [PTR_W-1:0]      r_tail;
   logic [CNT_WIDTH-1:0]  r_count;
   logic [0:0]            r_state;
   logic [0:0]            w_state_nxt;

   logic                  r_disp_valid;
   disp_rec_t             r_disp_rec;
   logic [DATA_WIDTH-1:0] r_disp_imm;
   logic [ADDR_WIDTH-1:0] r_disp_pc;
   logic                  r_redir_valid;
   logic [ADDR_WIDTH-1:0] r_redir_target;
   logic                  r_illegal;

   disp_rec_t             w_dec_rec;
   logic [DATA_WIDTH-1:0] w_dec_imm;
   logic [ADDR_WIDTH-1:0] w_dec_target;
   logic                  w_dec_nop;
   logic                  w_dec_illegal;
   logic                  w_dec_jal;

   logic w_nonempty;
   logic w_br_handoff;
   logic w_take;
   logic w_load;
   logic w_jal_take;
   logic w_enq;

   inst_decode_comb #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_dec (
      .inst       (r_q_inst[r_head]),
      .pc         (r_q_pc[r_head]),
      .rec        (w_dec_rec),
      .imm        (w_dec_imm),
      .jal_target (w_dec_target),
      .is_nop     (w_dec_nop),
      .is_illegal (w_dec_illegal),
      .is_jal     (w_dec_jal)
   );

   assign w_nonempty   = (r_count != '0);
   assign w_br_handoff = r_disp_valid && disp_ready && (r_disp_rec.unit == UNIT_BRANCH);
   // The edge that hands off a branch already blocks the next load.
   assign w_take       = (r_state == S_RUN) && w_nonempty && (!r_disp_valid || disp_ready)
                         && !w_br_handoff;
   assign w_load       = w_take && !w_dec_nop && !w_dec_illegal;
   assign w_jal_take   = w_load && w_dec_jal;
   assign if_ready     = (r_count < CNT_WIDTH'(DEPTH)) && !flush && !w_jal_take;
   assign w_enq        = if_valid && if_ready;

   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_q_inst[r_tail] <= if_inst;
         r_q_pc[r_tail]   <= if_pc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head         <= '0;
         r_tail         <= '0;
         r_count        <= '0;
         r_disp_valid   <= 1'b0;
         r_disp_rec     <= '0;
         r_disp_imm     <= '0;
         r_disp_pc      <= '0;
         r_redir_valid  <= 1'b0;
         r_redir_target <= '0;
         r_illegal      <= 1'b0;
      end else if (flush) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_disp_valid  <= 1'b0;
         r_redir_valid <= 1'b0;
         r_illegal     <= 1'b0;
      end else begin
         r_redir_valid <= w_jal_take;
         r_illegal     <= w_take && w_dec_illegal && !w_dec_nop;
         if (w_jal_take)
            r_redir_target <= w_dec_target;

         if (w_enq)
            r_tail <= r_tail + PTR_W'(1);
         // A taken JAL discards everything younger; no enqueue can coincide.
         if (w_jal_take) begin
            r_head  <= r_tail;
            r_count <= '0;
         end else begin
            if (w_take)
               r_head <= r_head + PTR_W'(1);
            r_count <= r_count + CNT_WIDTH'(w_enq) - CNT_WIDTH'(w_take);
         end

         if (w_load) begin
            r_disp_valid <= 1'b1;
            r_disp_rec   <= w_dec_rec;
            r_disp_imm   <= w_dec_imm;
            r_disp_pc    <= r_q_pc[r_head];
         end else if (disp_ready) begin
            r_disp_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= S_RUN;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = S_RUN;
      end else begin
         case (r_state)
            S_RUN:     if (w_br_handoff) w_state_nxt = S_WAIT_BR;
            S_WAIT_BR: if (br_resolve)   w_state_nxt = S_RUN;
            default:   w_state_nxt = S_RUN;
         endcase
      end
   end

   always_comb begin
      waiting_branch = (r_state == S_WAIT_BR);
   end

   assign disp_valid         = r_disp_valid;
   assign disp_unit          = r_disp_rec.unit;
   assign disp_op            = r_disp_rec.op;
   assign disp_rd            = r_disp_rec.rd;
   assign disp_rs1           = r_disp_rec.rs1;
   assign disp_rs2           = r_disp_rec.rs2;
   assign disp_imm           = r_disp_imm;
   assign disp_pc            = r_disp_pc;
   assign pc_redirect_valid  = r_redir_valid;
   assign pc_redirect_target = r_redir_target;
   assign illegal_inst       = r_illegal;
   assign queue_count        = r_count;

endmodule

`default_nettype wire

// File: tb/tb_decode_dispatch_queue.sv
// ============================================================================
//  Module      : tb_decode_dispatch_queue
//  Description : Directed self-checking bench for decode_dispatch_queue.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_decode_dispatch_queue;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_valid;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_ready;
   logic        flush;
   logic        br_resolve;
   logic        disp_valid;
   logic        disp_ready;
   logic [1:0]  disp_unit;
   logic [5:0]  disp_op;
   logic [4:0]  disp_rd;
   logic [4:0]  disp_rs1;
   logic [4:0]  disp_rs2;
   logic [31:0] disp_imm;
   logic [31:0] disp_pc;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect_target;
   logic        illegal_inst;
   logic [2:0]  queue_count;
   logic        waiting_branch;

   int n_total = 0;
   int n_bad   = 0;

   decode_dispatch_queue u_dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .if_valid           (if_valid),
      .if_inst            (if_inst),
      .if_pc              (if_pc),
      .if_ready           (if_ready),
      .flush              (flush),
      .br_resolve         (br_resolve),
      .disp_valid         (disp_valid),
      .disp_ready         (disp_ready),
      .disp_unit          (disp_unit),
      .disp_op            (disp_op),
      .disp_rd            (disp_rd),
      .disp_rs1           (disp_rs1),
      .disp_rs2           (disp_rs2),
      .disp_imm           (disp_imm),
      .disp_pc            (disp_pc),
      .pc_redirect_valid  (pc_redirect_valid),
      .pc_redirect_target (pc_redirect_target),
      .illegal_inst       (illegal_inst),
      .queue_count        (queue_count),
      .waiting_branch     (waiting_branch)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] inst, input logic [31:0] pc);
      if_valid = 1'b1;
      if_inst  = inst;
      if_pc    = pc;
      tick();
      if_valid = 1'b0;
   endtask

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
      return {imm, 5'd0, 3'd0, rd, 7'h13};
   endfunction

   int ill_seen;
   int dv_seen;

   initial begin
      rst_n = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0;
      flush = 1'b0; br_resolve = 1'b0; disp_ready = 1'b0;
      tick(); tick();
      chk("rst_disp_valid", disp_valid, 0);
      chk("rst_count", queue_count, 0);
      chk("rst_waiting", waiting_branch, 0);
      chk("rst_redirect", pc_redirect_valid, 0);
      chk("rst_illegal", illegal_inst, 0);
      chk("rst_rd", disp_rd, 0);
      chk("rst_pc", disp_pc, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_if_ready", if_ready, 1);

      // ADDI x1,x0,5 with two-cycle fill latency
      disp_ready = 1'b1;
      push(32'h0050_0093, 32'h100);
      chk("addi_count1", queue_count, 1);
      chk("addi_not_yet", disp_valid, 0);
      tick();
      chk("addi_valid", disp_valid, 1);
      chk("addi_unit", disp_unit, 0);
      chk("addi_op", disp_op, 0);
      chk("addi_rd", disp_rd, 1);
      chk("addi_rs1", disp_rs1, 0);
      chk("addi_rs2", disp_rs2, 0);
      chk("addi_imm", disp_imm, 5);
      chk("addi_pc", disp_pc, 32'h100);
      chk("addi_count0", queue_count, 0);
      tick();
      chk("addi_handed", disp_valid, 0);

      // Fill with downstream stalled, then drain in order across the wrap
      disp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if_valid = 1'b1;
         if_inst  = addi(5'(i + 1), 12'(10 + i));
         if_pc    = 32'h300 + 32'(4 * i);
         tick();
      end
      if_inst = addi(5'd6, 12'd99);
      if_pc   = 32'h3F0;
      chk("full_count", queue_count, 4);
      chk("full_if_ready", if_ready, 0);
      tick();
      if_valid = 1'b0;
      chk("full_hold_count", queue_count, 4);
      chk("stable_rd", disp_rd, 1);
      chk("stable_imm", disp_imm, 10);
      disp_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tick();
         chk("drain_rd", disp_rd, 64'(i + 1));
         chk("drain_imm", disp_imm, 64'(10 + i));
         chk("drain_pc", disp_pc, 64'(32'h300 + 4 * i));
      end
      tick();
      chk("drain_done_valid", disp_valid, 0);
      chk("drain_done_count", queue_count, 0);

      // BEQ x1,x2,+8 then ADD x3,x1,x2
      push(32'h0020_8463, 32'h400);
      push(32'h0020_81B3, 32'h404);
      chk("beq_valid", disp_valid, 1);
      chk("beq_unit", disp_unit, 1);
      chk("beq_op", disp_op, 18);
      chk("beq_imm", disp_imm, 8);
      chk("beq_rs1", disp_rs1, 1);
      chk("beq_rs2", disp_rs2, 2);
      tick();
      chk("beq_waiting", waiting_branch, 1);
      chk("beq_after_valid", disp_valid, 0);
      chk("beq_after_count", queue_count, 1);
      tick(); tick();
      chk("add_held", disp_valid, 0);
      chk("still_waiting", waiting_branch, 1);
      br_resolve = 1'b1;
      tick();
      br_resolve = 1'b0;
      chk("resolve_run", waiting_branch, 0);
      tick();
      chk("add_valid", disp_valid, 1);
      chk("add_rd", disp_rd, 3);
      chk("add_rs2", disp_rs2, 2);
      chk("add_op", disp_op, 0);
      chk("add_pc", disp_pc, 32'h404);
      tick();
      chk("add_handed", disp_valid, 0);

      // JAL x1,+16 with two younger entries behind it
      disp_ready = 1'b0;
      push(addi(5'd7, 12'd1), 32'h1F0);
      push(32'h0100_00EF, 32'h200);
      push(addi(5'd8, 12'd2), 32'h204);
      push(addi(5'd9, 12'd3), 32'h208);
      chk("jal_pre_count", queue_count, 3);
      chk("jal_pre_rd", disp_rd, 7);
      disp_ready = 1'b1;
      #1;
      chk("jal_if_ready", if_ready, 0);
      tick();
      chk("jal_redirect", pc_redirect_valid, 1);
      chk("jal_target", pc_redirect_target, 32'h210);
      chk("jal_count", queue_count, 0);
      chk("jal_op", disp_op, 26);
      chk("jal_imm", disp_imm, 16);
      chk("jal_pc", disp_pc, 32'h200);
      tick();
      chk("jal_pulse_end", pc_redirect_valid, 0);
      chk("jal_handed", disp_valid, 0);
      chk("jal_count_after", queue_count, 0);

      // Flush while waiting on a branch with a full queue and a concurrent offer
      push(32'h0020_9463, 32'h500);
      tick(); tick();
      chk("bne_waiting", waiting_branch, 1);
      for (int i = 0; i < 4; i++)
         push(addi(5'(10 + i), 12'(i)), 32'h600 + 32'(4 * i));
      chk("wait_fill_count", queue_count, 4);
      if_valid = 1'b1;
      if_inst  = addi(5'd20, 12'd20);
      flush    = 1'b1;
      #1;
      chk("flush_if_ready", if_ready, 0);
      tick();
      flush    = 1'b0;
      if_valid = 1'b0;
      chk("flush_count", queue_count, 0);
      chk("flush_run", waiting_branch, 0);
      chk("flush_valid", disp_valid, 0);

      // Flush drops a held record
      disp_ready = 1'b0;
      push(addi(5'd11, 12'd4), 32'h700);
      tick();
      chk("pre_flush_valid", disp_valid, 1);
      push(addi(5'd12, 12'd4), 32'h704);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush2_valid", disp_valid, 0);
      chk("flush2_count", queue_count, 0);

      // NOP and illegal never dispatch; one illegal pulse
      disp_ready = 1'b1;
      ill_seen = 0;
      dv_seen  = 0;
      push(32'h0000_0013, 32'h800);
      push(32'hFFFF_FFFF, 32'h804);
      for (int i = 0; i < 6; i++) begin
         if (illegal_inst) ill_seen++;
         if (disp_valid) dv_seen++;
         tick();
      end
      chk("illegal_pulses", 64'(ill_seen), 1);
      chk("nop_ill_no_dispatch", 64'(dv_seen), 0);
      chk("nop_ill_count", queue_count, 0);

      // Asynchronous reset mid-operation
      disp_ready = 1'b0;
      push(addi(5'd13, 12'd5), 32'h900);
      tick();
      push(addi(5'd14, 12'd6), 32'h904);
      chk("pre_arst_count", queue_count, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_count", queue_count, 0);
      chk("arst_valid", disp_valid, 0);
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
